decodificador_sete_segmentos: RTL
=================================

// Module: decodificador_sete_segmentos
// PURPOSE
//   Receive side of the seven-segment display interface: samples the seven active-low
//   segment lines A..G and qualifies each pattern as stable. Converts each stable pattern
//   back into a BCD digit or a status class (blank, dash, error).
//   Used as on-chip readback/self-check of the display encoder outputs, and to count
//   malformed patterns.
// PARAMETERS
//   ESTAVEL   3   consecutive identical samples required before a pattern is accepted (>=1)
//   W_ERROS   8   width of the saturating malformed-pattern counter
// PORTS
//   clock     in   1        rising-edge system clock
//   reset     in   1        asynchronous, active-low reset
//   A..G      in   1 each   segment lines, active-low (0 = segment lit); A is MSB of pattern
//   numero    out  4        decoded digit 0..9; 4'hF when last accepted pattern is not a digit
//   valido    out  1        last accepted pattern is a digit 0..9
//   apagado   out  1        last accepted pattern is blank (no segment lit)
//   traco     out  1        last accepted pattern is dash (only G lit)
//   erro      out  1        last accepted pattern matches no known class
//   instavel  out  1        a pattern change is pending qualification
//   novo      out  1        one-cycle pulse on every acceptance
//   erros     out  W_ERROS  count of accepted error patterns, saturating
// BEHAVIOUR
//   Sampling
//   - Every edge, {A,B,C,D,E,F,G} is captured into the input register amostra.
//   - s = ~amostra is the active-high pattern, s[6] = A.
//   FSM: AGUARDA (qualifying) / FIRME (accepted)
//   - Counter cnt counts consecutive edges on which the captured value equals the
//     previous amostra.
//   - E0 is the first edge capturing a new value; cnt resets to 0 there.
//   - AGUARDA -> FIRME: if inputs stay unchanged through edge E0+ESTAVEL-1, class
//     outputs update and novo=1 at edge E0+ESTAVEL.
//     Latency = ESTAVEL cycles after first capture.
//   - FIRME -> AGUARDA: on any captured change.
//   - The change cancels any in-progress qualification; cnt restarts from 0.
//   - instavel = 1 exactly while in AGUARDA.
//   - Class outputs hold the last accepted result while in AGUARDA; they never show an
//     unqualified pattern.
//   - In FIRME with unchanged input: cnt saturates, novo = 0, and no re-acceptance occurs.
//   Classification of s (exactly one of valido/apagado/traco/erro is 1 after the first
//   acceptance)
//   - digit table:
//     0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//     5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//   - digit hit -> numero = digit, valido = 1
//   - s = 0000000 -> apagado = 1, numero = 4'hF
//   - s = 0000001 -> traco = 1, numero = 4'hF
//   - any other s -> erro = 1, numero = 4'hF
//   - Each error acceptance increments erros by 1; at all-ones it holds.
//   - Acceptance of the same error pattern happens once per qualification, not per cycle.
//   Reset (asynchronous, reset = 0)
//   - amostra = 7'b1111111, cnt = 0, state AGUARDA.
//   - numero = 4'hF, erros = 0; valido/apagado/traco/erro/novo = 0.
//   - instavel = 1.
//   - Reset mid-qualification discards the pending pattern.
//   - After release, blank lines are accepted as apagado ESTAVEL edges after the first
//     post-reset capture.
//   ESTAVEL = 1: pattern accepted on the edge after first capture; novo pulses once per
//   distinct stable pattern.
// TESTING
//   T1 reset=0, random A..G -> all class outputs 0, numero=F, erros=0, instavel=1;
//      release with A..G=1111111 -> apagado=1 with one-cycle novo after 3 cycles
//   T2 hold A..G=~0110000 -> numero=1, valido=1, novo pulses exactly once at E0+3,
//      instavel falls the same edge
//   T3 from digit 1: drive ~1101101 for 2 cycles, then back to ~0110000 -> numero stays 1,
//      novo never pulses, instavel=1 during glitch
//   T4 hold s=1000001 -> erro=1, numero=F, erros=1; hold longer -> erros stays 1
//   T5 W_ERROS=2: four separate error acceptances interleaved with digit 5 -> erros=3
//      (saturated); digit 5 gives valido=1, numero=5
//   T6 hold s=0000001 -> traco=1, numero=F; assert reset 1 cycle into a new digit 7
//      qualification -> reset values, digit 7 never reported

Source files
------------

// File: rtl/decodificador_sete_segmentos.sv
// Seven-segment receive side: samples the active-low segment lines, qualifies a
// pattern once it has been stable long enough, and classifies it back into a BCD
// digit or a status class (blank, dash, error). Accepted error patterns are counted.
module decodificador_sete_segmentos #(
    parameter int unsigned ESTAVEL = 3,
    parameter int unsigned W_ERROS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               A,
    input  logic               B,
    input  logic               C,
    input  logic               D,
    input  logic               E,
    input  logic               F,
    input  logic               G,
    output logic [3:0]         numero,
    output logic               valido,
    output logic               apagado,
    output logic               traco,
    output logic               erro,
    output logic               instavel,
    output logic               novo,
    output logic [W_ERROS-1:0] erros
);

    localparam int unsigned CW = (ESTAVEL > 1) ? $clog2(ESTAVEL) : 1;
    localparam logic [CW-1:0] CMAX = CW'(ESTAVEL - 1);

    typedef enum logic {
        AGUARDA = 1'b0,
        FIRME   = 1'b1
    } estado_t;

    estado_t      estado;
    estado_t      estado_prox;
    logic [6:0]   amostra;
    logic [6:0]   linhas;
    logic [6:0]   s;
    logic [CW-1:0] cnt;
    logic         fresco;
    logic         mudou;
    logic         aceita;

    logic [3:0]   numero_c;
    logic         valido_c;
    logic         apagado_c;
    logic         traco_c;
    logic         erro_c;

    assign linhas = {A, B, C, D, E, F, G};
    assign s      = ~amostra;

    // Change detection, acceptance decision and next state.
    // The first capture after reset always counts as a new value, so the reset
    // content of amostra is never accepted as if it had been sampled.
    always_comb begin
        mudou       = fresco || (linhas != amostra);
        aceita      = (estado == AGUARDA) && !fresco && (cnt == CMAX);
        estado_prox = estado;
        if (mudou) begin
            estado_prox = AGUARDA;
        end else if (aceita) begin
            estado_prox = FIRME;
        end
    end

    // Pattern classification of the currently held sample.
    always_comb begin
        numero_c  = 4'hF;
        valido_c  = 1'b0;
        apagado_c = 1'b0;
        traco_c   = 1'b0;
        erro_c    = 1'b0;
        case (s)
            7'b1111110: begin numero_c = 4'd0; valido_c = 1'b1; end
            7'b0110000: begin numero_c = 4'd1; valido_c = 1'b1; end
            7'b1101101: begin numero_c = 4'd2; valido_c = 1'b1; end
            7'b1111001: begin numero_c = 4'd3; valido_c = 1'b1; end
            7'b0110011: begin numero_c = 4'd4; valido_c = 1'b1; end
            7'b1011011: begin numero_c = 4'd5; valido_c = 1'b1; end
            7'b1011111: begin numero_c = 4'd6; valido_c = 1'b1; end
            7'b1110000: begin numero_c = 4'd7; valido_c = 1'b1; end
            7'b1111111: begin numero_c = 4'd8; valido_c = 1'b1; end
            7'b1111011: begin numero_c = 4'd9; valido_c = 1'b1; end
            7'b0000000: apagado_c = 1'b1;
            7'b0000001: traco_c   = 1'b1;
            default:    erro_c    = 1'b1;
        endcase
    end

    // Sampling, stability counter, state and registered class outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            amostra  <= 7'b1111111;
            fresco   <= 1'b1;
            cnt      <= '0;
            estado   <= AGUARDA;
            instavel <= 1'b1;
            numero   <= 4'hF;
            valido   <= 1'b0;
            apagado  <= 1'b0;
            traco    <= 1'b0;
            erro     <= 1'b0;
            novo     <= 1'b0;
            erros    <= '0;
        end else begin
            amostra  <= linhas;
            fresco   <= 1'b0;
            estado   <= estado_prox;
            instavel <= (estado_prox == AGUARDA);
            novo     <= aceita;

            if (mudou) begin
                cnt <= '0;
            end else if (cnt != CMAX) begin
                cnt <= cnt + CW'(1);
            end

            if (aceita) begin
                numero  <= numero_c;
                valido  <= valido_c;
                apagado <= apagado_c;
                traco   <= traco_c;
                erro    <= erro_c;
                if (erro_c && (erros != '1)) begin
                    erros <= erros + W_ERROS'(1);
                end
            end
        end
    end

endmodule
